gba_bus_slave: RTL and testbench
================================

GBA_BUS_SLAVE -- requirements
Module: gba_bus_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning width of the latched/incremented half-word address.
REQ-002 SHALL have parameter MEM_AW, default 10, meaning the ROM address width; MEM_ADDR = address[MEM_AW-1:0].
REQ-003 SHALL have port CLK  in  1  PLL clock; all logic rising-edge.
REQ-004 SHALL have port RESETB  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports CS, RD, WR  in  1 each  raw asynchronous GBA strobes, active-low.
REQ-006 SHALL have port A_IN  in  16  AD bus input value from the pad primitive.
REQ-007 SHALL have ports D_OUT  out  16  read data to the pad, and OE  out  1  pad output enable.
REQ-008 SHALL have ports MEM_ADDR  out  MEM_AW  ROM address, MEM_RE  out  1  ROM read strobe, and MEM_RDATA  in  16  ROM data (valid 1 cycle after MEM_RE).
REQ-009 SHALL have ports WR_STB  out  1  one-cycle write pulse, WR_ADDR  out  ADDR_W  write address, and WR_DATA  out  16  write data.
REQ-010 SHALL have port ERR  out  1  sticky protocol-error flag.

Function
REQ-011 SHALL pass CS, RD and WR each through a 3-stage shift register; edges are taken from bits [2:1] (fall = 10, rise = 01); level is bit [1].
REQ-012 SHALL implement FSM states IDLE, ACTIVE, FETCH, DRIVE and WRITE.
REQ-013 In any state, a CS fall SHALL latch address <= A_IN and enter ACTIVE; a CS fall has priority over every other event in the same cycle.
REQ-014 In any non-IDLE state, a CS rise SHALL enter IDLE and deassert OE in the same cycle; any pending fetch is discarded.
REQ-015 ACTIVE, on RD fall: assert MEM_RE for 1 cycle with MEM_ADDR = address, then enter FETCH.
REQ-016 FETCH SHALL last 1 cycle, register D_OUT <= MEM_RDATA, set OE = 1, and enter DRIVE; D_OUT is therefore valid 3 cycles after the raw RD fall reaches the synchroniser.
REQ-017 DRIVE, on RD rise: OE = 0, address <= address + 1, return to ACTIVE.
REQ-018 ACTIVE, on WR fall: capture WR_DATA <= A_IN and WR_ADDR <= address, then enter WRITE.
REQ-019 WRITE SHALL pulse WR_STB high for exactly 1 cycle.
REQ-020 On WR rise in WRITE or ACTIVE after a write: address <= address + 1, state ACTIVE.
REQ-021 Address increment SHALL be modulo 2^ADDR_W (0xFFFF -> 0x0000); MEM_ADDR SHALL truncate to the low MEM_AW bits.
REQ-022 If RD fall and WR fall occur in the same cycle in ACTIVE, the read SHALL win, no WR_STB SHALL be produced, and ERR SHALL be set.
REQ-023 A WR fall in FETCH/DRIVE or an RD fall in WRITE SHALL set ERR and be otherwise ignored.
REQ-024 RD/WR edges while CS is high (IDLE) SHALL be ignored without setting ERR.
REQ-025 OE SHALL be 1 only in DRIVE; it SHALL never be 1 while the synchronised CS is high.
REQ-026 ERR SHALL remain set until reset.

Reset
REQ-027 While RESETB = 0 at a clock edge: state IDLE, history registers all 1s (bus idle), address 0, D_OUT 0, OE 0, MEM_RE 0, WR_STB 0, WR_ADDR 0, WR_DATA 0, ERR 0.
REQ-028 Reset asserted mid-transfer SHALL drop OE on the next edge; after release the block SHALL wait for a fresh CS fall, with no spurious edge from the all-1s history.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the 3-bit history width and the edge patterns (2'b10, 2'b01).
REQ-030 SHALL contain one sub-module, edge_sync (3-stage synchroniser with fall/rise/level outputs), instantiated three times.
REQ-031 The ROM array and SB_IO pads SHALL stay outside the block.

Verification
REQ-032 Apply CS fall with A_IN = 0x0010, then 3 RD pulses with the ROM model returning address*2 -> D_OUT = 0x0020, 0x0022, 0x0024 under OE; MEM_ADDR 0x10, 0x11, 0x12.
REQ-033 Apply CS fall with A_IN = 0x0400, then a WR pulse with A_IN = 0x03FF -> a single WR_STB with WR_ADDR = 0x0400 and WR_DATA = 0x03FF; address then reads 0x0401.
REQ-034 Latch 0xFFFF, then 2 reads -> MEM_ADDR 0x3FF then 0x000; internal address wraps to 0x0000.
REQ-035 Raise CS while in DRIVE -> OE = 0 the same cycle, state IDLE; an RD pulse with CS high gives no MEM_RE and ERR = 0.
REQ-036 Fall RD and WR in the same cycle -> read completes, no WR_STB, ERR = 1 and remains 1 until RESETB.
REQ-037 Assert RESETB = 0 during FETCH -> all outputs zero the next cycle; after release, RD pulses produce no MEM_RE until a new CS fall.

Source files
------------

// File: rtl/gba_bus_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gba_bus_slave_pkg
//  Purpose  : Shared FSM encoding, strobe history width and edge patterns
//             for the GBA cartridge bus slave.
//  Revision : 1.0  initial release
// ============================================================================
package gba_bus_slave_pkg;

  // Bus slave transaction states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DRIVE  = 3'd3,
    ST_WRITE  = 3'd4
  } state_t;

  // Strobe synchroniser depth; edges come from the two oldest bits
  localparam int         c_HIST_W    = 3;
  localparam logic [1:0] c_EDGE_FALL = 2'b10;
  localparam logic [1:0] c_EDGE_RISE = 2'b01;

endpackage
`default_nettype wire

// File: rtl/gba_bus_slave_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : edge_sync
//  Purpose  : 3-stage synchroniser for one raw active-low GBA strobe with
//             fall / rise pulses and a synchronised level.
//  Revision : 1.0  initial release
// ============================================================================
module edge_sync (
  input  logic CLK,
  input  logic RESETB,
  input  logic i_raw,
  output logic o_fall,
  output logic o_rise,
  output logic o_level
);
  import gba_bus_slave_pkg::*;

  logic [c_HIST_W-1:0] r_hist;

  // Shift the raw strobe in; reset to all-ones so an idle bus shows no edge
  always_ff @(posedge CLK) begin
    if (!RESETB) r_hist <= '1;
    else         r_hist <= {r_hist[c_HIST_W-2:0], i_raw};
  end

  assign o_fall  = (r_hist[2:1] == c_EDGE_FALL);
  assign o_rise  = (r_hist[2:1] == c_EDGE_RISE);
  assign o_level = r_hist[1];

endmodule
`default_nettype wire

// File: rtl/gba_bus_slave.sv
`default_nettype none
// ============================================================================
//  Module   : gba_bus_slave
//  Purpose  : GBA cartridge AD-bus slave. Latches the half-word address on
//             CS fall, serves ROM reads with auto-increment and emits a
//             one-cycle write strobe for bus writes. Protocol violations set a
//             sticky error flag.
//  Revision : 1.0  initial release
// ============================================================================
module gba_bus_slave #(
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 10
) (
  input  logic              CLK,
  input  logic              RESETB,
  input  logic              CS,
  input  logic              RD,
  input  logic              WR,
  input  logic [15:0]       A_IN,
  output logic [15:0]       D_OUT,
  output logic              OE,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic              MEM_RE,
  input  logic [15:0]       MEM_RDATA,
  output logic              WR_STB,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [15:0]       WR_DATA,
  output logic              ERR
);
  import gba_bus_slave_pkg::*;

  // Synchronised strobe events
  logic w_cs_fall, w_cs_rise, w_cs_level;
  logic w_rd_fall, w_rd_rise, w_rd_level;
  logic w_wr_fall, w_wr_rise, w_wr_level;
  logic w_unused_levels;

  edge_sync u_sync_cs (
    .CLK(CLK), .RESETB(RESETB), .i_raw(CS),
    .o_fall(w_cs_fall), .o_rise(w_cs_rise), .o_level(w_cs_level)
  );
  edge_sync u_sync_rd (
    .CLK(CLK), .RESETB(RESETB), .i_raw(RD),
    .o_fall(w_rd_fall), .o_rise(w_rd_rise), .o_level(w_rd_level)
  );
  edge_sync u_sync_wr (
    .CLK(CLK), .RESETB(RESETB), .i_raw(WR),
    .o_fall(w_wr_fall), .o_rise(w_wr_rise), .o_level(w_wr_level)
  );

  // RD/WR levels are not needed: all RD/WR decisions are edge driven
  assign w_unused_levels = w_rd_level ^ w_wr_level;

  state_t              r_state, w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_dout;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [15:0]         r_wr_data;
  logic                r_wr_stb;
  logic                r_err;
  logic                r_wr_open;    // write seen, WR rise still outstanding

  logic w_load_addr, w_inc_addr, w_load_dout, w_cap_wr, w_set_err, w_mem_re;
  logic w_wr_open_nxt;

  // State register
  always_ff @(posedge CLK) begin
    if (!RESETB) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state and datapath control; CS events take precedence over RD/WR
  always_comb begin
    w_next_state  = r_state;
    w_load_addr   = 1'b0;
    w_inc_addr    = 1'b0;
    w_load_dout   = 1'b0;
    w_cap_wr      = 1'b0;
    w_set_err     = 1'b0;
    w_mem_re      = 1'b0;
    w_wr_open_nxt = r_wr_open;

    if (w_cs_fall) begin
      w_next_state  = ST_ACTIVE;
      w_load_addr   = 1'b1;
      w_wr_open_nxt = 1'b0;
    end else if (w_cs_rise && (r_state != ST_IDLE)) begin
      w_next_state  = ST_IDLE;
      w_wr_open_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (w_rd_fall) begin
            // A simultaneous WR fall loses to the read and is flagged
            w_mem_re     = 1'b1;
            w_next_state = ST_FETCH;
            w_set_err    = w_wr_fall;
          end else if (w_wr_fall) begin
            w_cap_wr      = 1'b1;
            w_wr_open_nxt = 1'b1;
            w_next_state  = ST_WRITE;
          end else if (w_wr_rise && r_wr_open) begin
            w_inc_addr    = 1'b1;
            w_wr_open_nxt = 1'b0;
          end
        end
        ST_FETCH: begin
          w_load_dout  = 1'b1;
          w_set_err    = w_wr_fall;
          w_next_state = ST_DRIVE;
        end
        ST_DRIVE: begin
          w_set_err = w_wr_fall;
          if (w_rd_rise) begin
            w_inc_addr   = 1'b1;
            w_next_state = ST_ACTIVE;
          end
        end
        ST_WRITE: begin
          // Strobe is one cycle; the WR rise may land here or in ACTIVE
          w_set_err    = w_rd_fall;
          w_next_state = ST_ACTIVE;
          if (w_wr_rise) begin
            w_inc_addr    = 1'b1;
            w_wr_open_nxt = 1'b0;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Address, read data, write capture and sticky error registers
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      r_addr    <= '0;
      r_dout    <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_stb  <= 1'b0;
      r_err     <= 1'b0;
      r_wr_open <= 1'b0;
    end else begin
      if (w_load_addr)     r_addr <= ADDR_W'(A_IN);
      else if (w_inc_addr) r_addr <= r_addr + 1'b1;
      if (w_load_dout)     r_dout <= MEM_RDATA;
      if (w_cap_wr) begin
        r_wr_addr <= r_addr;
        r_wr_data <= A_IN;
      end
      r_wr_stb  <= w_cap_wr;
      r_wr_open <= w_wr_open_nxt;
      if (w_set_err) r_err <= 1'b1;
    end
  end

  assign MEM_ADDR = r_addr[MEM_AW-1:0];
  assign MEM_RE   = w_mem_re;
  assign D_OUT    = r_dout;
  assign OE       = (r_state == ST_DRIVE) && !w_cs_level;
  assign WR_STB   = r_wr_stb;
  assign WR_ADDR  = r_wr_addr;
  assign WR_DATA  = r_wr_data;
  assign ERR      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gba_bus_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gba_bus_slave
//  Purpose  : Directed self-checking bench for gba_bus_slave.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gba_bus_slave;
  import gba_bus_slave_pkg::*;

  logic        CLK = 1'b0;
  logic        RESETB;
  logic        CS, RD, WR;
  logic [15:0] A_IN;
  logic [15:0] D_OUT;
  logic        OE;
  logic [9:0]  MEM_ADDR;
  logic        MEM_RE;
  logic [15:0] MEM_RDATA;
  logic        WR_STB;
  logic [15:0] WR_ADDR;
  logic [15:0] WR_DATA;
  logic        ERR;

  int checks   = 0;
  int failures = 0;

  int         re_cnt  = 0;
  int         stb_cnt = 0;
  logic [9:0] last_re_addr = '0;
  logic [15:0] rom_q = '0;

  gba_bus_slave #(.ADDR_W(16), .MEM_AW(10)) dut (
    .CLK(CLK), .RESETB(RESETB), .CS(CS), .RD(RD), .WR(WR), .A_IN(A_IN),
    .D_OUT(D_OUT), .OE(OE), .MEM_ADDR(MEM_ADDR), .MEM_RE(MEM_RE),
    .MEM_RDATA(MEM_RDATA), .WR_STB(WR_STB), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Synchronous ROM model: data = address * 2, one cycle after MEM_RE
  always @(posedge CLK) begin
    if (MEM_RE) begin
      rom_q        <= {5'b0, MEM_ADDR, 1'b0};
      re_cnt       = re_cnt + 1;
      last_re_addr = MEM_ADDR;
    end
    if (WR_STB) stb_cnt = stb_cnt + 1;
  end
  assign MEM_RDATA = rom_q;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Return to idle, then open a transaction at the given address
  task automatic cs_start(input logic [15:0] addr);
    CS = 1'b1;
    tick(4);
    A_IN = addr;
    CS   = 1'b0;
    tick(4);
  endtask

  task automatic test_reset;
    RESETB = 1'b0; CS = 1'b1; RD = 1'b1; WR = 1'b1; A_IN = 16'h0;
    tick(3);
    checks++;
    if ({OE, MEM_RE, WR_STB, ERR} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0000", {OE, MEM_RE, WR_STB, ERR});
    end
    checks++;
    if ({D_OUT, WR_DATA, WR_ADDR} !== 48'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", {D_OUT, WR_DATA, WR_ADDR});
    end
    RESETB = 1'b1;
    tick(4);
    checks++;
    if (dut.r_state !== ST_IDLE || re_cnt !== 0) begin
      failures++;
      $display("FAIL reset_release: got state %0d re %0d expected 0 0", dut.r_state, re_cnt);
    end
  endtask

  task automatic test_read_burst;
    logic [15:0] exp_d [3];
    logic [9:0]  exp_a [3];
    exp_d[0] = 16'h0020; exp_d[1] = 16'h0022; exp_d[2] = 16'h0024;
    exp_a[0] = 10'h010;  exp_a[1] = 10'h011;  exp_a[2] = 10'h012;
    cs_start(16'h0010);
    for (int i = 0; i < 3; i++) begin
      RD = 1'b0;
      tick(4);
      checks++;
      if (OE !== 1'b1 || D_OUT !== exp_d[i]) begin
        failures++;
        $display("FAIL read_data[%0d]: got OE=%b D=%h expected OE=1 D=%h", i, OE, D_OUT, exp_d[i]);
      end
      checks++;
      if (last_re_addr !== exp_a[i]) begin
        failures++;
        $display("FAIL read_addr[%0d]: got %h expected %h", i, last_re_addr, exp_a[i]);
      end
      RD = 1'b1;
      tick(3);
      checks++;
      if (OE !== 1'b0) begin
        failures++;
        $display("FAIL read_oe_off[%0d]: got %b expected 0", i, OE);
      end
    end
    checks++;
    if (re_cnt !== 3) begin
      failures++;
      $display("FAIL read_re_count: got %0d expected 3", re_cnt);
    end
  endtask

  task automatic test_write;
    int stb0;
    cs_start(16'h0400);
    stb0 = stb_cnt;
    A_IN = 16'h03FF;
    WR   = 1'b0;
    tick(4);
    WR   = 1'b1;
    tick(4);
    checks++;
    if (stb_cnt !== stb0 + 1) begin
      failures++;
      $display("FAIL write_stb_count: got %0d expected %0d", stb_cnt, stb0 + 1);
    end
    checks++;
    if (WR_ADDR !== 16'h0400 || WR_DATA !== 16'h03FF) begin
      failures++;
      $display("FAIL write_capture: got A=%h D=%h expected A=0400 D=03ff", WR_ADDR, WR_DATA);
    end
    checks++;
    if (dut.r_addr !== 16'h0401 || MEM_ADDR !== 10'h001) begin
      failures++;
      $display("FAIL write_incr: got %h/%h expected 0401/001", dut.r_addr, MEM_ADDR);
    end
  endtask

  task automatic test_wrap;
    cs_start(16'hFFFF);
    RD = 1'b0;
    tick(4);
    checks++;
    if (last_re_addr !== 10'h3FF || D_OUT !== 16'h07FE) begin
      failures++;
      $display("FAIL wrap_read0: got A=%h D=%h expected A=3ff D=07fe", last_re_addr, D_OUT);
    end
    RD = 1'b1;
    tick(3);
    checks++;
    if (dut.r_addr !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_addr: got %h expected 0000", dut.r_addr);
    end
    RD = 1'b0;
    tick(4);
    checks++;
    if (last_re_addr !== 10'h000 || D_OUT !== 16'h0000 || OE !== 1'b1) begin
      failures++;
      $display("FAIL wrap_read1: got A=%h D=%h OE=%b expected 000 0000 1", last_re_addr, D_OUT, OE);
    end
    RD = 1'b1;
    tick(3);
  endtask

  task automatic test_cs_abort;
    int re0;
    cs_start(16'h0050);
    RD = 1'b0;
    tick(4);
    CS = 1'b1;
    tick(1);
    checks++;
    if (OE !== 1'b1) begin
      failures++;
      $display("FAIL abort_oe_before: got %b expected 1", OE);
    end
    tick(1);
    checks++;
    if (OE !== 1'b0 || dut.r_state !== ST_DRIVE) begin
      failures++;
      $display("FAIL abort_oe_same_cycle: got OE=%b state=%0d expected 0 %0d", OE, dut.r_state, ST_DRIVE);
    end
    tick(1);
    checks++;
    if (dut.r_state !== ST_IDLE || OE !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got state=%0d OE=%b expected 0 0", dut.r_state, OE);
    end
    RD = 1'b1;
    tick(4);
    re0 = re_cnt;
    RD = 1'b0;
    tick(4);
    RD = 1'b1;
    tick(4);
    checks++;
    if (re_cnt !== re0 || ERR !== 1'b0) begin
      failures++;
      $display("FAIL idle_rd_ignored: got re=%0d err=%b expected %0d 0", re_cnt, ERR, re0);
    end
  endtask

  task automatic test_back_to_back_rd_wr;
    int stb0;
    cs_start(16'h0020);
    stb0 = stb_cnt;
    RD = 1'b0;
    WR = 1'b0;
    tick(4);
    checks++;
    if (OE !== 1'b1 || D_OUT !== 16'h0040 || ERR !== 1'b1) begin
      failures++;
      $display("FAIL collide_read: got OE=%b D=%h ERR=%b expected 1 0040 1", OE, D_OUT, ERR);
    end
    RD = 1'b1;
    WR = 1'b1;
    tick(4);
    checks++;
    if (stb_cnt !== stb0) begin
      failures++;
      $display("FAIL collide_no_stb: got %0d expected %0d", stb_cnt, stb0);
    end
    cs_start(16'h0030);
    checks++;
    if (ERR !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: got %b expected 1", ERR);
    end
  endtask

  task automatic test_reset_mid_fetch;
    int re0;
    RD = 1'b0;
    tick(3);
    checks++;
    if (dut.r_state !== ST_FETCH) begin
      failures++;
      $display("FAIL rst_setup_fetch: got %0d expected %0d", dut.r_state, ST_FETCH);
    end
    RESETB = 1'b0;
    CS     = 1'b1;
    RD     = 1'b1;
    tick(1);
    checks++;
    if ({OE, MEM_RE, WR_STB, ERR} !== 4'b0000 || {D_OUT, WR_DATA, WR_ADDR} !== 48'h0
        || MEM_ADDR !== 10'h000) begin
      failures++;
      $display("FAIL rst_mid_fetch: got ctl=%b data=%h ma=%h expected 0", {OE, MEM_RE, WR_STB, ERR},
               {D_OUT, WR_DATA, WR_ADDR}, MEM_ADDR);
    end
    tick(2);
    RESETB = 1'b1;
    tick(4);
    re0 = re_cnt;
    RD = 1'b0;
    tick(4);
    RD = 1'b1;
    tick(4);
    checks++;
    if (re_cnt !== re0 || dut.r_state !== ST_IDLE) begin
      failures++;
      $display("FAIL rst_no_spurious: got re=%0d state=%0d expected %0d 0", re_cnt, dut.r_state, re0);
    end
    cs_start(16'h0031);
    RD = 1'b0;
    tick(4);
    checks++;
    if (re_cnt !== re0 + 1 || D_OUT !== 16'h0062 || OE !== 1'b1) begin
      failures++;
      $display("FAIL rst_recover: got re=%0d D=%h OE=%b expected %0d 0062 1", re_cnt, D_OUT, OE, re0 + 1);
    end
    RD = 1'b1;
    tick(3);
    CS = 1'b1;
    tick(4);
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write();
    test_wrap();
    test_cs_abort();
    test_back_to_back_rd_wr();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
